// File: rtl/rv32_fpu_pkg.sv
// Shared FP32 definitions for the RV32F execute-stage arithmetic units.
// Contents: FSM state enum, the unpacked FP32 operand struct and its unpack
// helper (subnormals flushed to signed zero), and FP32 / fflags constants.
package rv32_fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_NORM,
    ST_DONE
  } fsm_state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;     // hidden bit included; zero for zero/subnormal
    logic        is_zero;  // true zero or flushed subnormal
    logic        is_inf;
    logic        is_nan;
    logic        is_snan;
  } fp32_unpacked_t;

  localparam logic [31:0]        FP32_CANON_NAN = 32'h7FC0_0000;
  localparam logic signed [9:0]  FP32_BIAS      = 10'sd127;

  // fflags bit positions: {NV, DZ, OF, UF, NX}
  localparam int unsigned FFLAG_NX = 0;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_NV = 4;

  function automatic fp32_unpacked_t fp32_unpack(input logic [31:0] x);
    fp32_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.is_zero = (x[30:23] == 8'h00);
    u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == '0);
    u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    u.is_snan = u.is_nan && !x[22];
    u.mant    = u.is_zero ? '0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/rv32_e_fpu_round.sv
// Combinational RNE rounder and FP32 packer.
// Inputs : sign_i, exp_i (10-bit signed biased exponent), mant_i (1.f[22:0]
//          followed by guard and round bits), sticky_i.
// Outputs: result_o (packed FP32), fflags_o ({NV,DZ,OF,UF,NX}; only OF/UF/NX
//          can be set here). Overflow saturates to signed Inf, underflow
//          flushes to signed zero.
module rv32_e_fpu_round
  import rv32_fpu_pkg::*;
(
  input  logic               sign_i,
  input  logic signed [9:0]  exp_i,
  input  logic [25:0]        mant_i,
  input  logic               sticky_i,
  output logic [31:0]        result_o,
  output logic [4:0]         fflags_o
);

  logic              lsb;
  logic              guard;
  logic              rnd;
  logic              inexact;
  logic              round_up;
  logic [24:0]       sum;
  logic              carry;
  logic signed [9:0] exp_r;
  logic [22:0]       frac;

  always_comb begin
    lsb      = mant_i[2];
    guard    = mant_i[1];
    rnd      = mant_i[0];
    inexact  = guard | rnd | sticky_i;
    round_up = guard & (rnd | sticky_i | lsb);
    sum      = {1'b0, mant_i[25:2]} + {24'd0, round_up};
    carry    = sum[24];
    // A carry means the significand rounded up to exactly 2.0
    exp_r    = carry ? exp_i + 10'sd1 : exp_i;
    frac     = carry ? sum[23:1] : sum[22:0];

    fflags_o = '0;
    if (exp_r >= 10'sd255) begin
      result_o           = {sign_i, 8'hFF, 23'd0};
      fflags_o[FFLAG_OF] = 1'b1;
      fflags_o[FFLAG_NX] = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      result_o           = {sign_i, 31'd0};
      fflags_o[FFLAG_UF] = 1'b1;
      fflags_o[FFLAG_NX] = 1'b1;
    end else begin
      result_o           = {sign_i, exp_r[7:0], frac};
      fflags_o[FFLAG_NX] = inexact;
    end
  end

endmodule

// File: rtl/rv32_e_fpu_divsqrt.sv
// Iterative FDIV.S / FSQRT.S unit (restoring, one quotient/root bit per cycle).
// Ports: clk_i, rst_ni (async active-low), start_i, op_sqrt_i, src_a_i,
//        src_b_i, flush_i -> busy_o, valid_o (one-cycle strobe), result_o,
//        fflags_o ({NV,DZ,OF,UF,NX}).
// Build option: FPU_SQRT_EN enables the square-root datapath; without it an
// FSQRT request completes immediately as canonical NaN with NV.
module rv32_e_fpu_divsqrt
  import rv32_fpu_pkg::*;
#(
  parameter int unsigned QBITS = 26
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        op_sqrt_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o
);

  localparam int unsigned REMW = QBITS + 4;
  localparam int unsigned CNTW = $clog2(QBITS);

  fsm_state_e state_q, state_d;

  fp32_unpacked_t ua, ub;
  logic           spec_hit;
  logic [31:0]    spec_res;
  logic [4:0]     spec_flags;

  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [QBITS-1:0]  q_q, q_d;
  logic [REMW-1:0]   rem_q, rem_d;
  logic [23:0]       dvs_q, dvs_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic [4:0]        fflags_q, fflags_d;
  logic              valid_q, valid_d;

  logic signed [9:0] div_exp;
  logic              div_lt;
  logic [REMW-1:0]   dvs_ext;

  logic [QBITS:0]    q_ext;
  logic [25:0]       rnd_mant;
  logic              rnd_sticky;
  logic [31:0]       rnd_res;
  logic [4:0]        rnd_flags;

`ifdef FPU_SQRT_EN
  localparam int unsigned RADW = 2 * QBITS;
  logic              sqrt_q, sqrt_d;
  logic [RADW-1:0]   rad_q, rad_d;
  logic [REMW-1:0]   rem_sh;
  logic [REMW-1:0]   trial;
  logic signed [9:0] sqrt_u;
  logic [24:0]       sqrt_m;
`endif

  // Operand classification and special-case results
  always_comb begin
    ua         = fp32_unpack(src_a_i);
    ub         = fp32_unpack(src_b_i);
    spec_hit   = 1'b1;
    spec_res   = FP32_CANON_NAN;
    spec_flags = '0;
    if (op_sqrt_i) begin
`ifdef FPU_SQRT_EN
      if (ua.is_nan) begin
        spec_flags[FFLAG_NV] = ua.is_snan;
      end else if (ua.is_zero) begin
        spec_res = {ua.sign, 31'd0};
      end else if (ua.sign) begin
        spec_flags[FFLAG_NV] = 1'b1;
      end else if (ua.is_inf) begin
        spec_res = 32'h7F80_0000;
      end else begin
        spec_hit = 1'b0;
      end
`else
      spec_flags[FFLAG_NV] = 1'b1;
`endif
    end else begin
      if (ua.is_nan || ub.is_nan) begin
        spec_flags[FFLAG_NV] = ua.is_snan | ub.is_snan;
      end else if ((ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
        spec_flags[FFLAG_NV] = 1'b1;
      end else if (ua.is_inf) begin
        spec_res = {ua.sign ^ ub.sign, 8'hFF, 23'd0};
      end else if (ub.is_inf || ua.is_zero) begin
        spec_res = {ua.sign ^ ub.sign, 31'd0};
      end else if (ub.is_zero) begin
        spec_res             = {ua.sign ^ ub.sign, 8'hFF, 23'd0};
        spec_flags[FFLAG_DZ] = 1'b1;
      end else begin
        spec_hit = 1'b0;
      end
    end
  end

  // Rounder input: top 26 quotient bits; any lower bits fold into sticky
  always_comb begin
    q_ext      = {q_q, 1'b0};
    rnd_mant   = q_ext[QBITS -: 26];
    rnd_sticky = (rem_q != '0) | (|q_ext[QBITS-26:0]);
  end

  rv32_e_fpu_round u_round (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .mant_i   (rnd_mant),
    .sticky_i (rnd_sticky),
    .result_o (rnd_res),
    .fflags_o (rnd_flags)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over everything, including a new start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = spec_hit ? ST_DONE : ST_ITER;
      ST_ITER: if (cnt_q == CNTW'(QBITS - 1)) state_d = ST_NORM;
      ST_NORM: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Outputs
  always_comb begin
    busy_o   = (state_q != ST_IDLE);
    valid_o  = valid_q;
    result_o = result_q;
    fflags_o = fflags_q;
  end

  // Datapath next-state
  always_comb begin
    sign_d   = sign_q;
    exp_d    = exp_q;
    q_d      = q_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    fflags_d = fflags_q;
    valid_d  = 1'b0;
    div_exp  = $signed({2'b00, ua.exp}) - $signed({2'b00, ub.exp}) + FP32_BIAS;
    div_lt   = (ua.mant < ub.mant);
    dvs_ext  = {{(REMW-24){1'b0}}, dvs_q};
`ifdef FPU_SQRT_EN
    sqrt_d   = sqrt_q;
    rad_d    = rad_q;
    rem_sh   = {rem_q[REMW-3:0], rad_q[RADW-1 -: 2]};
    trial    = {{(REMW-QBITS-2){1'b0}}, q_q, 2'b01};
    sqrt_u   = '0;
    sqrt_m   = '0;
`endif
    if (!flush_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (spec_hit) begin
              result_d = spec_res;
              fflags_d = spec_flags;
              valid_d  = 1'b1;
            end else begin
              cnt_d = '0;
              q_d   = '0;
`ifdef FPU_SQRT_EN
              sqrt_d = op_sqrt_i;
              if (op_sqrt_i) begin
                // Even unbiased exponent so the root exponent is exact
                sign_d = 1'b0;
                sqrt_u = $signed({2'b00, ua.exp}) - FP32_BIAS;
                sqrt_m = {1'b0, ua.mant};
                if (sqrt_u[0]) begin
                  sqrt_m = {ua.mant, 1'b0};
                  sqrt_u = sqrt_u - 10'sd1;
                end
                exp_d = (sqrt_u >>> 1) + FP32_BIAS;
                rad_d = {sqrt_m, {(RADW-25){1'b0}}};
                rem_d = '0;
              end else
`endif
              begin
                // Pre-scale the dividend so the quotient lies in [1,2)
                sign_d = ua.sign ^ ub.sign;
                dvs_d  = ub.mant;
                if (div_lt) begin
                  rem_d = REMW'({ua.mant, 1'b0});
                  exp_d = div_exp - 10'sd1;
                end else begin
                  rem_d = REMW'(ua.mant);
                  exp_d = div_exp;
                end
              end
            end
          end
        end
        ST_ITER: begin
          cnt_d = cnt_q + CNTW'(1);
`ifdef FPU_SQRT_EN
          if (sqrt_q) begin
            rad_d = rad_q << 2;
            if (rem_sh >= trial) begin
              rem_d = rem_sh - trial;
              q_d   = {q_q[QBITS-2:0], 1'b1};
            end else begin
              rem_d = rem_sh;
              q_d   = {q_q[QBITS-2:0], 1'b0};
            end
          end else
`endif
          begin
            if (rem_q >= dvs_ext) begin
              rem_d = (rem_q - dvs_ext) << 1;
              q_d   = {q_q[QBITS-2:0], 1'b1};
            end else begin
              rem_d = rem_q << 1;
              q_d   = {q_q[QBITS-2:0], 1'b0};
            end
          end
        end
        ST_NORM: begin
          result_d = rnd_res;
          fflags_d = rnd_flags;
          valid_d  = 1'b1;
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      q_q      <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      fflags_q <= '0;
      valid_q  <= 1'b0;
`ifdef FPU_SQRT_EN
      sqrt_q   <= 1'b0;
      rad_q    <= '0;
`endif
    end else begin
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      q_q      <= q_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
      valid_q  <= valid_d;
`ifdef FPU_SQRT_EN
      sqrt_q   <= sqrt_d;
      rad_q    <= rad_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv32_e_fpu_divsqrt.sv
// Self-checking bench for rv32_e_fpu_divsqrt: directed cases, randomized
// operands against an exact-arithmetic reference, flush/start/reset checks.
module tb_rv32_e_fpu_divsqrt;

  localparam logic [31:0] NAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op_sqrt = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [4:0]  fflags;

  int unsigned checks = 0;
  int unsigned failures = 0;

  rv32_e_fpu_divsqrt #(.QBITS(26)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .op_sqrt_i (op_sqrt),
    .src_a_i   (src_a),
    .src_b_i   (src_b),
    .flush_i   (flush),
    .busy_o    (busy),
    .valid_o   (valid),
    .result_o  (result),
    .fflags_o  (fflags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned s;
    s = longint'($sqrt(real'(x)));
    while (s * s > x) s--;
    while ((s + 1) * (s + 1) <= x) s++;
    return s;
  endfunction

  function automatic void pack(input logic s, input int e_in, input longint unsigned k_in,
                               input logic inexact, output logic [31:0] res, output logic [4:0] fl);
    int e;
    longint unsigned k;
    e = e_in;
    k = k_in;
    if (k == (64'd1 << 24)) begin
      k = k >> 1;
      e++;
    end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'd0};
      fl  = 5'b00101;
    end else if (e <= 0) begin
      res = {s, 31'd0};
      fl  = 5'b00011;
    end else begin
      res = {s, 8'(e), 23'(k)};
      fl  = {4'b0000, inexact};
    end
  endfunction

  function automatic void model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [4:0] fl, output logic spec);
    logic sa, sb, s, za, zb, ia, ib, na, nb, sna, snb, up;
    int ea, eb, e;
    longint unsigned ma, mb, num, k, r;
    sa  = a[31];
    sb  = b[31];
    s   = sa ^ sb;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    za  = (ea == 0);
    zb  = (eb == 0);
    ia  = (ea == 255) && (a[22:0] == 0);
    ib  = (eb == 255) && (b[22:0] == 0);
    na  = (ea == 255) && (a[22:0] != 0);
    nb  = (eb == 255) && (b[22:0] != 0);
    sna = na && !a[22];
    snb = nb && !b[22];
    ma  = za ? 0 : (64'h80_0000 | 64'(a[22:0]));
    mb  = zb ? 0 : (64'h80_0000 | 64'(b[22:0]));
    res  = NAN;
    fl   = '0;
    spec = 1'b1;
    if (op) begin
`ifdef FPU_SQRT_EN
      if (na) fl[4] = sna;
      else if (za) res = {sa, 31'd0};
      else if (sa) fl[4] = 1'b1;
      else if (ia) res = 32'h7F80_0000;
      else begin
        spec = 1'b0;
        e    = ea - 127;
        num  = ma;
        if ((e % 2) != 0) begin
          num = 2 * ma;
          e   = e - 1;
        end
        e   = e / 2 + 127;
        num = num << 23;
        k   = isqrt(num);
        r   = num - k * k;
        up  = (r > k);
        pack(1'b0, e, k + 64'(up), r != 0, res, fl);
      end
`else
      fl[4] = 1'b1;
`endif
    end else begin
      if (na || nb) fl[4] = sna | snb;
      else if ((za && zb) || (ia && ib)) fl[4] = 1'b1;
      else if (ia) res = {s, 8'hFF, 23'd0};
      else if (ib || za) res = {s, 31'd0};
      else if (zb) begin
        res = {s, 8'hFF, 23'd0};
        fl  = 5'b01000;
      end else begin
        spec = 1'b0;
        e    = ea - eb + 127;
        num  = ma;
        if (ma < mb) begin
          num = 2 * ma;
          e   = e - 1;
        end
        num = num << 23;
        k   = num / mb;
        r   = num % mb;
        up  = (2 * r > mb) || ((2 * r == mb) && k[0]);
        pack(s, e, k + 64'(up), r != 0, res, fl);
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    int unsigned cls;
    logic        s;
    logic [22:0] f;
    cls = $urandom_range(0, 23);
    s   = 1'($urandom);
    f   = 23'($urandom);
    case (cls)
      0: return {s, 31'd0};
      1: return {s, 8'd0, f | 23'd1};
      2: return {s, 8'hFF, 23'd0};
      3: return {s, 8'hFF, 1'b1, f[21:0]};
      4: return {s, 8'hFF, 1'b0, f[21:0] | 22'd1};
      5: return {s, 8'($urandom_range(1, 12)), f};
      6: return {s, 8'($urandom_range(240, 254)), f};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  // ---------------- transaction ----------------
  task automatic run_op(input string tag, input logic op, input logic [31:0] xa,
                        input logic [31:0] xb, input bit noise, input logic [31:0] exp_res,
                        input logic [4:0] exp_fl, input int exp_lat);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    op_sqrt = op;
    src_a   = xa;
    src_b   = xb;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (noise && c == 5) begin
        start   = 1'b1;
        op_sqrt = ~op;
        src_a   = $urandom;
        src_b   = $urandom;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (valid === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
    start = 1'b0;
    check_eq({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".busy"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, ".res"}, result, exp_res);
    check_eq({tag, ".flags"}, {27'd0, fflags}, {27'd0, exp_fl});
    tick();
    check_eq({tag, ".after"}, {30'd0, busy, valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb, er;
    logic [4:0]  ef;
    logic        sp, op;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.ctl", {30'd0, busy, valid}, 32'd0);
    check_eq("reset.res", result, 32'd0);
    check_eq("reset.flags", {27'd0, fflags}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("div6_2", 1'b0, 32'h40C0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 5'b00000, 28);
    run_op("div1_0", 1'b0, 32'h3F80_0000, 32'h0000_0000, 1'b0, 32'h7F80_0000, 5'b01000, 1);
    run_op("divovf", 1'b0, 32'h7F7F_FFFF, 32'h3F00_0000, 1'b1, 32'h7F80_0000, 5'b00101, 28);
    run_op("divaa",  1'b0, 32'hBFC0_0000, 32'h3FC0_0000, 1'b1, 32'hBF80_0000, 5'b00000, 28);
    run_op("sqrtm4", 1'b1, 32'hC080_0000, 32'h0,         1'b0, NAN,           5'b10000, 1);
`ifdef FPU_SQRT_EN
    run_op("sqrt2",  1'b1, 32'h4000_0000, 32'h0,         1'b0, 32'h3FB5_04F3, 5'b00001, 28);
    run_op("sqrt4",  1'b1, 32'h4080_0000, 32'h0,         1'b1, 32'h4000_0000, 5'b00000, 28);
`else
    run_op("sqrt4",  1'b1, 32'h4080_0000, 32'h0,         1'b0, NAN,           5'b10000, 1);
`endif
    run_op("div1_3", 1'b0, 32'h3F80_0000, 32'h4040_0000, 1'b0, 32'h3EAA_AAAB, 5'b00001, 28);

    // flush in cycle 10 of a divide; previous result must persist
    op_sqrt = 1'b0;
    src_a   = 32'h40C0_0000;
    src_b   = 32'h4000_0000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check_eq("flush.busy10", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush.idle", {30'd0, busy, valid}, 32'd0);
    check_eq("flush.res", result, 32'h3EAA_AAAB);
    check_eq("flush.flags", {27'd0, fflags}, 32'd1);
    run_op("restart", 1'b0, 32'h3F80_0000, 32'h3F00_0000, 1'b0, 32'h4000_0000, 5'b00000, 28);

    // flush during the rounding cycle leaves outputs untouched
    src_a = 32'h3F80_0000;
    src_b = 32'h4040_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (26) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flushnorm.idle", {30'd0, busy, valid}, 32'd0);
    check_eq("flushnorm.res", result, 32'h4000_0000);

    // flush and start together: start is dropped
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check_eq("flushstart", {30'd0, busy, valid}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 2) == 0);
      ra = rand_fp();
      rb = rand_fp();
      if (op && $urandom_range(0, 3) != 0) ra[31] = 1'b0;
      model(op, ra, rb, er, ef, sp);
      run_op(op ? "rnd_sqrt" : "rnd_div", op, ra, rb, ($urandom_range(0, 1) == 1), er, ef, sp ? 1 : 28);
    end

    // asynchronous reset in the middle of an operation
    op_sqrt = 1'b0;
    src_a   = 32'h3F80_0000;
    src_b   = 32'h4040_0000;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid.ctl", {30'd0, busy, valid}, 32'd0);
    check_eq("rstmid.res", result, 32'd0);
    check_eq("rstmid.flags", {27'd0, fflags}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_op("postrst", 1'b0, 32'h40C0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 5'b00000, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
